// File: rtl/maxpool_stage.sv
// maxpool_stage
// Reads the IN_W x IN_W layer-0 feature map from the shared result memory,
// applies 2x2 / stride-2 max pooling and writes the (IN_W/2) x (IN_W/2)
// layer-1 map back to the same memory. One output takes six cycles:
// four tap reads, one cycle to absorb the last read's data, one write.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   one-cycle request to pool the whole map (IDLE only)
//   busy      out  high while a map is being processed
//   done      out  one-cycle pulse after the last write
//   crd       out  read strobe, data returns on cdata_rd one cycle later
//   caddr_rd  out  read address
//   cdata_rd  in   read data (signed)
//   cwr       out  write strobe
//   caddr_wr  out  write address
//   cdata_wr  out  write data (pooled maximum)
//   csel      out  memory bank select
module maxpool_stage #(
  parameter int          DW     = 20,
  parameter int          IN_W   = 64,
  parameter int          AW     = 12,
  parameter logic [2:0]  RD_SEL = 3'b001,
  parameter logic [2:0]  WR_SEL = 3'b011
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  // Bits needed for an output-map row/column index.
  localparam int HW = $clog2(IN_W / 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LAST  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Input address of tap k of output (r, c): row 2r / 2r+1, column 2c / 2c+1.
  function automatic logic [AW-1:0] rd_addr_f(input logic [HW-1:0] r,
                                               input logic [HW-1:0] c,
                                               input logic [1:0]    k);
    logic [AW-1:0] base;
    base = (AW'(r) << (HW + 2)) | (AW'(c) << 1);
    rd_addr_f = base + (k[1] ? AW'(IN_W) : {AW{1'b0}}) + {{(AW-1){1'b0}}, k[0]};
  endfunction

  // Output-map address of output (r, c).
  function automatic logic [AW-1:0] wr_addr_f(input logic [HW-1:0] r,
                                              input logic [HW-1:0] c);
    wr_addr_f = (AW'(r) << HW) | AW'(c);
  endfunction

  state_t          state_r, state_nxt_s;
  logic [HW-1:0]   r_r, r_nxt_s;
  logic [HW-1:0]   c_r, c_nxt_s;
  logic [1:0]      k_r, k_nxt_s;
  logic [DW-1:0]   max_r, max_nxt_s;

  logic            busy_r, busy_nxt_s;
  logic            done_r, done_nxt_s;
  logic            crd_r, crd_nxt_s;
  logic            cwr_r, cwr_nxt_s;
  logic [2:0]      csel_r, csel_nxt_s;
  logic [AW-1:0]   caddr_rd_r, caddr_rd_nxt_s;
  logic [AW-1:0]   caddr_wr_r, caddr_wr_nxt_s;
  logic [DW-1:0]   cdata_wr_r, cdata_wr_nxt_s;

  logic            sample_s;

  // Next-state, counter and running-maximum logic.
  always_comb begin
    state_nxt_s = state_r;
    r_nxt_s     = r_r;
    c_nxt_s     = c_r;
    k_nxt_s     = k_r;
    max_nxt_s   = max_r;

    // Data on cdata_rd belongs to the read issued one cycle earlier, so the
    // samples land in READ k=1..3 and in LAST.
    sample_s = ((state_r == ST_READ) && (k_r != 2'd0)) || (state_r == ST_LAST);
    if (sample_s) begin
      if ((state_r == ST_READ) && (k_r == 2'd1)) begin
        max_nxt_s = cdata_rd;
      end else if ($signed(cdata_rd) > $signed(max_r)) begin
        max_nxt_s = cdata_rd;
      end else begin
        max_nxt_s = max_r;
      end
    end else begin
      max_nxt_s = max_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (k_r == 2'd3) begin
          k_nxt_s     = 2'd0;
          state_nxt_s = ST_LAST;
        end else begin
          k_nxt_s     = k_r + 2'd1;
        end
      end
      ST_LAST: begin
        state_nxt_s = ST_WRITE;
      end
      ST_WRITE: begin
        if (c_r == {HW{1'b1}}) begin
          c_nxt_s = {HW{1'b0}};
          if (r_r == {HW{1'b1}}) begin
            r_nxt_s     = {HW{1'b0}};
            state_nxt_s = ST_DONE;
          end else begin
            r_nxt_s     = r_r + {{(HW-1){1'b0}}, 1'b1};
            state_nxt_s = ST_READ;
          end
        end else begin
          c_nxt_s     = c_r + {{(HW-1){1'b0}}, 1'b1};
          state_nxt_s = ST_READ;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so that
  // every output can be driven straight from a flop.
  always_comb begin
    busy_nxt_s     = 1'b0;
    done_nxt_s     = 1'b0;
    crd_nxt_s      = 1'b0;
    cwr_nxt_s      = 1'b0;
    csel_nxt_s     = 3'b000;
    caddr_rd_nxt_s = caddr_rd_r;
    caddr_wr_nxt_s = caddr_wr_r;
    cdata_wr_nxt_s = cdata_wr_r;
    case (state_nxt_s)
      ST_READ: begin
        busy_nxt_s     = 1'b1;
        crd_nxt_s      = 1'b1;
        csel_nxt_s     = RD_SEL;
        caddr_rd_nxt_s = rd_addr_f(r_nxt_s, c_nxt_s, k_nxt_s);
      end
      ST_LAST: begin
        busy_nxt_s = 1'b1;
        csel_nxt_s = RD_SEL;
      end
      ST_WRITE: begin
        busy_nxt_s     = 1'b1;
        cwr_nxt_s      = 1'b1;
        csel_nxt_s     = WR_SEL;
        caddr_wr_nxt_s = wr_addr_f(r_nxt_s, c_nxt_s);
        cdata_wr_nxt_s = max_nxt_s;
      end
      ST_DONE: begin
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counters, running maximum and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      r_r        <= {HW{1'b0}};
      c_r        <= {HW{1'b0}};
      k_r        <= 2'd0;
      max_r      <= {DW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      crd_r      <= 1'b0;
      cwr_r      <= 1'b0;
      csel_r     <= 3'b000;
      caddr_rd_r <= {AW{1'b0}};
      caddr_wr_r <= {AW{1'b0}};
      cdata_wr_r <= {DW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      r_r        <= r_nxt_s;
      c_r        <= c_nxt_s;
      k_r        <= k_nxt_s;
      max_r      <= max_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      crd_r      <= crd_nxt_s;
      cwr_r      <= cwr_nxt_s;
      csel_r     <= csel_nxt_s;
      caddr_rd_r <= caddr_rd_nxt_s;
      caddr_wr_r <= caddr_wr_nxt_s;
      cdata_wr_r <= cdata_wr_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign crd      = crd_r;
  assign cwr      = cwr_r;
  assign csel     = csel_r;
  assign caddr_rd = caddr_rd_r;
  assign caddr_wr = caddr_wr_r;
  assign cdata_wr = cdata_wr_r;

endmodule

// File: tb/tb_maxpool_stage.sv
// Directed testbench for maxpool_stage: ramp image, signed/tie/extreme blocks,
// cycle timing, start abuse and mid-operation reset, against a memory model.
module tb_maxpool_stage;

  localparam int DW = 20;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, crd, cwr;
  logic [AW-1:0] caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd = {DW{1'b0}};
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  logic [DW-1:0] l0 [0:4095];
  logic [DW-1:0] l1 [0:1023];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int e0 = 0;

  // Written only by the memory/bus monitor.
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr_q = {AW{1'b0}};
  int busy_cnt = 0, done_cnt = 0, wr_cnt = 0, w100_cnt = 0;
  int excl_err = 0, csel_err = 0, seq_err = 0, done_busy_err = 0;
  int wr_idx = 0, wr0_rel = 0, done_rel = 0;

  maxpool_stage dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model and bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cdata_rd = rd_pend ? l0[rd_addr_q] : {DW{1'b0}};
    rd_pend = crd;
    rd_addr_q = caddr_rd;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_rel = cyc - e0 + 1;
      if (busy) done_busy_err++;
    end
    if (crd && cwr) excl_err++;
    if (crd && csel !== 3'b001) csel_err++;
    if (cwr && csel !== 3'b011) csel_err++;
    if (!reset) begin
      wr_idx = 0;
    end else if (cwr) begin
      wr_cnt++;
      l1[caddr_wr] = cdata_wr;
      if (caddr_wr !== 12'(wr_idx)) seq_err++;
      if (caddr_wr == 12'd100) w100_cnt++;
      if (caddr_wr == 12'd0) wr0_rel = cyc - e0 + 1;
      wr_idx = (wr_idx + 1) % 1024;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Raise start for one sampling edge; returns at the negedge of cycle 1.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int bad, busy0, wr0, done0, w100_0, n, r, c;

    for (int a = 0; a < 4096; a++) l0[a] = 20'(a);
    for (int a = 0; a < 1024; a++) l1[a] = {DW{1'b0}};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_crd", 32'(crd), 32'd0);
    chk("rst_cwr", 32'(cwr), 32'd0);
    chk("rst_csel", 32'(csel), 32'd0);
    chk("rst_caddr_rd", 32'(caddr_rd), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Pass 1: ramp image with start abuse.
    busy0 = busy_cnt; wr0 = wr_cnt; done0 = done_cnt;
    pulse_start();
    chk("c1_crd", 32'(crd), 32'd1);
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_csel", 32'(csel), 32'd1);
    chk("c1_addr_tap0", 32'(caddr_rd), 32'd0);
    @(negedge clk);
    chk("c2_addr_tap1", 32'(caddr_rd), 32'd1);
    @(negedge clk);
    chk("c3_addr_tap2", 32'(caddr_rd), 32'd64);
    repeat (97) @(negedge clk);
    start = 1'b1;                       // cycle 100
    @(negedge clk);
    start = 1'b0;
    repeat (6043) @(negedge clk);
    start = 1'b1;                       // cycle 6144, last WRITE
    chk("c6144_cwr", 32'(cwr), 32'd1);
    chk("c6144_waddr", 32'(caddr_wr), 32'd1023);
    chk("c6144_wdata", 32'(cdata_wr), 32'd4095);
    @(negedge clk);                     // cycle 6145, DONE (start still high)
    chk("c6145_done", 32'(done), 32'd1);
    chk("c6145_busy", 32'(busy), 32'd0);
    @(negedge clk);                     // cycle 6146
    start = 1'b0;
    chk("no_restart_busy", 32'(busy), 32'd0);
    chk("done_single", 32'(done), 32'd0);
    chk("done_count", 32'(done_cnt - done0), 32'd1);
    chk("busy_cycles", 32'(busy_cnt - busy0), 32'd6144);
    chk("write_count", 32'(wr_cnt - wr0), 32'd1024);
    chk("first_cwr_cycle", 32'(wr0_rel), 32'd6);
    chk("done_cycle", 32'(done_rel), 32'd6145);
    chk("ramp_L1_0", 32'(l1[0]), 32'd65);
    chk("ramp_L1_1", 32'(l1[1]), 32'd67);
    chk("ramp_L1_32", 32'(l1[32]), 32'd193);
    chk("ramp_L1_1023", 32'(l1[1023]), 32'd4095);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      r = i / 32; c = i % 32;
      if (l1[i] !== 20'((2 * r + 1) * 64 + 2 * c + 1)) bad++;
    end
    chk("ramp_all", 32'(bad), 32'd0);

    // Pass 2: signed compare, ties and extremes, started 2 cycles after done.
    l0[0] = 20'hFFFFB; l0[1] = 20'hFFFFE; l0[64] = 20'hFFFF9; l0[65] = 20'hFFFFD;
    l0[2] = 20'hFFFFF; l0[3] = 20'h00000; l0[66] = 20'h80000; l0[67] = 20'hFFFFE;
    l0[4] = 20'h7FFFF; l0[5] = 20'h7FFFF; l0[68] = 20'h7FFFF; l0[69] = 20'h7FFFF;
    l0[6] = 20'h00001; l0[7] = 20'h00002; l0[70] = 20'h00003; l0[71] = 20'h12345;
    l0[8] = 20'h00010; l0[9] = 20'hFFFF0; l0[72] = 20'h0000F; l0[73] = 20'h80000;
    @(negedge clk);                     // cycle 6147
    wr0 = wr_cnt;
    pulse_start();
    wait_done(6300, "pass2_done_timeout");
    chk("pass2_writes", 32'(wr_cnt - wr0), 32'd1024);
    chk("neg_L1_0", 32'(l1[0]), 32'h000FFFFE);
    chk("mixed_L1_1", 32'(l1[1]), 32'd0);
    chk("tie_L1_2", 32'(l1[2]), 32'h0007FFFF);
    chk("tap3_L1_3", 32'(l1[3]), 32'h00012345);
    chk("tap0_L1_4", 32'(l1[4]), 32'h00000010);
    chk("ramp_L1_5", 32'(l1[5]), 32'd75);

    // Pass 3: reset during output 100, READ k=2.
    @(negedge clk);
    pulse_start();
    repeat (602) @(negedge clk);        // cycle 603
    chk("o100_crd", 32'(crd), 32'd1);
    chk("o100_addr_tap2", 32'(caddr_rd), 32'd456);
    w100_0 = w100_cnt;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_crd", 32'(crd), 32'd0);
    chk("mid_rst_cwr", 32'(cwr), 32'd0);
    chk("mid_rst_csel", 32'(csel), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("no_write_100", 32'(w100_cnt - w100_0), 32'd0);
    pulse_start();
    n = 1;
    while (cwr !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("restart_cwr", 32'(cwr), 32'd1);
    chk("restart_cycle", 32'(cyc - e0 + 1), 32'd6);
    chk("restart_addr", 32'(caddr_wr), 32'd0);
    chk("restart_data", 32'(cdata_wr), 32'h000FFFFE);
    wait_done(6300, "pass3_done_timeout");

    // Properties watched over the whole run.
    chk("rd_wr_exclusive", 32'(excl_err), 32'd0);
    chk("csel_codes", 32'(csel_err), 32'd0);
    chk("write_sequence", 32'(seq_err), 32'd0);
    chk("done_without_busy", 32'(done_busy_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
